// File: rtl/host_portb_ctrl_pkg.sv
// host_portb_ctrl_pkg: shared defaults, channel indices and level width for the port B controller
package host_portb_ctrl_pkg;
    localparam int NCH_DEF = 5;
    localparam int DW_DEF = 16;
    localparam int AW_DEF = 10;
    typedef enum int {CH_GPS = 0, CH_MEM = 1, CH_RX = 2, CH_WF = 3, CH_TOS = 4} ch_e;
    function automatic int lvl_w(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/host_portb_ctrl_if.sv
// host_portb_ctrl_if: BRAM port B bus between the controller (master) and the FIFO memory (slave)
interface host_portb_ctrl_if import host_portb_ctrl_pkg::*; #(parameter int DW = DW_DEF, parameter int AW = AW_DEF);
    logic fifo_we;
    logic [AW-1:0] fifo_addr;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    modport master(output fifo_we, fifo_addr, fifo_din, input fifo_dout);
    modport slave(input fifo_we, fifo_addr, fifo_din, output fifo_dout);
endinterface

// File: rtl/host_portb_arb.sv
// host_portb_arb: one-hot grant over pending channels, fixed priority or round-robin (HOST_PORTB_RR_EN)
module host_portb_arb import host_portb_ctrl_pkg::*; #(parameter int NCH = NCH_DEF) (
`ifdef HOST_PORTB_RR_EN
    input  logic hb_clk,
    input  logic ha_rst,
`endif
    input  logic en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt
);
`ifdef HOST_PORTB_RR_EN
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    logic [IW-1:0] last, gi;
    // search starts just after the last granted channel
    always_comb begin
        gnt = '0;
        gi = last;
        for (int i = 0; i < NCH; i++) begin
            if (en && gnt == '0 && req[(int'(last) + 1 + i) % NCH]) begin
                gnt[(int'(last) + 1 + i) % NCH] = 1'b1;
                gi = IW'((int'(last) + 1 + i) % NCH);
            end
        end
    end
    // remember the most recent grant
    always_ff @(posedge hb_clk or posedge ha_rst)
        if (ha_rst) last <= IW'(NCH - 1);
        else if (|gnt) last <= gi;
`else
    assign gnt = en ? req & (~req + NCH'(1)) : '0;
`endif
endmodule

// File: rtl/host_portb_ctrl.sv
// host_portb_ctrl: port B FIFO controller with per-channel holding registers (HOST_PORTB_RR_EN selects round-robin)
module host_portb_ctrl import host_portb_ctrl_pkg::*; #(
    parameter int NCH = NCH_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic hb_clk,
    input  logic ha_rst,
    input  logic [NCH-1:0] ch_wr,
    input  logic [NCH*DW-1:0] ch_din,
    input  logic host_rd,
    input  logic host_clr,
    input  logic host_rdy,
    input  logic poll,
    input  logic ack,
    host_portb_ctrl_if.master fifo,
    output logic [DW-1:0] host_dout,
    output logic host_srq,
    output logic rdy,
    output logic [lvl_w(AW)-1:0] level,
    output logic ovfl,
    output logic coll_err,
    output logic rd_err
);
    localparam int LW = lvl_w(AW);
    logic [NCH-1:0] pend, gnt, drop;
    logic [DW-1:0] hold [NCH];
    logic [DW-1:0] gdat;
    logic [LW-1:0] wr_ptr, rd_ptr;
    logic full, pop, gv, gv_q;
    assign level = wr_ptr - rd_ptr;
    assign full = level[AW];
    assign pop = host_rd && level != '0;
    assign gv = |gnt;
    assign drop = ch_wr & pend & ~gnt;
    assign host_srq = poll & ack;
    host_portb_arb #(.NCH(NCH)) u_arb (
`ifdef HOST_PORTB_RR_EN
        .hb_clk(hb_clk),
        .ha_rst(ha_rst),
`endif
        .en(!host_rd && !full && !host_clr),
        .req(pend),
        .gnt(gnt)
    );
    // select the granted holding register
    always_comb begin
        gdat = '0;
        for (int i = 0; i < NCH; i++) if (gnt[i]) gdat = hold[i];
    end
    assign fifo.fifo_we = gv;
    assign fifo.fifo_din = gdat;
    assign fifo.fifo_addr = gv ? wr_ptr[AW-1:0] : rd_ptr[AW-1:0] + AW'(host_rd);
    assign host_dout = pop ? fifo.fifo_dout : '0;
    // pending bits: a grant frees the slot, a same-cycle strobe refills it
    always_ff @(posedge hb_clk or posedge ha_rst)
        if (ha_rst) pend <= '0;
        else if (host_clr) pend <= '0;
        else pend <= ch_wr | (pend & ~gnt);
    // holding registers keep the first word when the slot is still occupied
    always_ff @(posedge hb_clk or posedge ha_rst)
        if (ha_rst) for (int i = 0; i < NCH; i++) hold[i] <= '0;
        else for (int i = 0; i < NCH; i++) if (ch_wr[i] && !drop[i]) hold[i] <= ch_din[i*DW +: DW];
    // pointers and sticky error flags
    always_ff @(posedge hb_clk or posedge ha_rst)
        if (ha_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            gv_q <= 1'b0;
            ovfl <= 1'b0;
            coll_err <= 1'b0;
            rd_err <= 1'b0;
        end else if (host_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            gv_q <= 1'b0;
            ovfl <= 1'b0;
            coll_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + LW'(gv);
            rd_ptr <= rd_ptr + LW'(pop);
            gv_q <= gv;
            ovfl <= ovfl | (|drop & full);
            coll_err <= coll_err | (|drop & ~full);
            rd_err <= rd_err | (host_rd & gv_q);
        end
    // ready flag: service request clears, host_rdy sets
    always_ff @(posedge hb_clk or posedge ha_rst)
        if (ha_rst) rdy <= 1'b0;
        else if (host_srq) rdy <= 1'b0;
        else if (host_rdy) rdy <= 1'b1;
endmodule

// File: tb/tb_host_portb_ctrl.sv
// tb_host_portb_ctrl: directed and random stimulus against a queue-based reference of the port B controller
module tb_host_portb_ctrl;
    import host_portb_ctrl_pkg::*;
    localparam int NCH = 5, DW = 16, AW = 4, D = 1 << AW;
    logic hb_clk = 1'b0, ha_rst = 1'b1;
    always #5 hb_clk = ~hb_clk;
    logic [NCH-1:0] ch_wr;
    logic [NCH*DW-1:0] ch_din;
    logic host_rd, host_clr, host_rdy, poll, ack;
    logic [DW-1:0] host_dout;
    logic host_srq, rdy, ovfl, coll_err, rd_err;
    logic [AW:0] level;
    host_portb_ctrl_if #(.DW(DW), .AW(AW)) fif();
    logic [DW-1:0] mem [D];
    always @(posedge hb_clk) begin
        if (fif.fifo_we) mem[fif.fifo_addr] <= fif.fifo_din;
        fif.fifo_dout <= mem[fif.fifo_addr];
    end
    host_portb_ctrl #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .hb_clk(hb_clk), .ha_rst(ha_rst), .ch_wr(ch_wr), .ch_din(ch_din),
        .host_rd(host_rd), .host_clr(host_clr), .host_rdy(host_rdy), .poll(poll), .ack(ack),
        .fifo(fif), .host_dout(host_dout), .host_srq(host_srq), .rdy(rdy), .level(level),
        .ovfl(ovfl), .coll_err(coll_err), .rd_err(rd_err)
    );
    int npass = 0, nchk = 0;
    bit mp [NCH];
    logic [DW-1:0] mh [NCH];
    logic [DW-1:0] q [$];
    logic [AW-1:0] mwa;
    bit mco, mov, mre, mrdy, mpg;
    int mlast, eg;
    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        nchk++;
        assert (o === e) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    endtask
    task automatic mreset();
        q.delete();
        for (int k = 0; k < NCH; k++) begin mp[k] = 0; mh[k] = '0; end
        mwa = '0; mco = 0; mov = 0; mre = 0; mrdy = 0; mpg = 0; mlast = NCH - 1; eg = -1;
    endtask
    function automatic int pick();
        if (host_rd || host_clr || q.size() == D) return -1;
        for (int i = 0; i < NCH; i++) begin
`ifdef HOST_PORTB_RR_EN
            int j = (mlast + 1 + i) % NCH;
`else
            int j = i;
`endif
            if (mp[j]) return j;
        end
        return -1;
    endfunction
    task automatic check();
        logic [AW-1:0] ra;
        eg = pick();
        ra = mwa - AW'(q.size()) + AW'(host_rd);
        chk("we", fif.fifo_we, eg >= 0);
        if (eg >= 0) begin
            chk("waddr", fif.fifo_addr, mwa);
            chk("wdata", fif.fifo_din, mh[eg]);
        end else chk("raddr", fif.fifo_addr, ra);
        if (!(host_rd && mpg)) chk("dout", host_dout, (host_rd && q.size() > 0) ? q[0] : 0);
        chk("level", level, q.size());
        chk("coll", coll_err, mco);
        chk("ovfl", ovfl, mov);
        chk("rderr", rd_err, mre);
        chk("rdy", rdy, mrdy);
        chk("srq", host_srq, poll & ack);
    endtask
    task automatic update();
        bit full;
        full = q.size() == D;
        if (poll && ack) mrdy = 0;
        else if (host_rdy) mrdy = 1;
        if (host_clr) begin
            q.delete();
            for (int k = 0; k < NCH; k++) mp[k] = 0;
            mwa = '0; mco = 0; mov = 0; mre = 0; mpg = 0;
            return;
        end
        if (host_rd && mpg) mre = 1;
        if (host_rd && q.size() > 0) void'(q.pop_front());
        if (eg >= 0) begin q.push_back(mh[eg]); mp[eg] = 0; mwa++; mlast = eg; end
        for (int k = 0; k < NCH; k++)
            if (ch_wr[k]) begin
                if (mp[k]) begin if (full) mov = 1; else mco = 1; end
                else begin mp[k] = 1; mh[k] = ch_din[k*DW +: DW]; end
            end
        mpg = eg >= 0;
    endtask
    task automatic tick();
        @(negedge hb_clk);
        check();
        @(posedge hb_clk);
        update();
        #1;
    endtask
    task automatic idle();
        ch_wr = '0; host_rd = 0; host_clr = 0; host_rdy = 0; poll = 0; ack = 0;
    endtask
    task automatic strobe(input int k, input logic [DW-1:0] d);
        ch_wr[k] = 1'b1;
        ch_din[k*DW +: DW] = d;
    endtask
    task automatic clr();
        idle(); host_clr = 1; tick(); host_clr = 0;
    endtask
    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        idle(); ch_din = '0; mreset();
        #12;
        chk("rst_we", fif.fifo_we, 0); chk("rst_addr", fif.fifo_addr, 0); chk("rst_din", fif.fifo_din, 0);
        chk("rst_level", level, 0); chk("rst_dout", host_dout, 0); chk("rst_rdy", rdy, 0);
        chk("rst_flags", {ovfl, coll_err, rd_err, host_srq}, 0);
        @(posedge hb_clk); #1; ha_rst = 0;
        strobe(0, 16'h1111); strobe(2, 16'h3333); strobe(4, 16'h5555); tick();
        idle(); repeat (4) tick();
        chk("sim_level", level, 3); chk("sim_coll", coll_err, 0);
        strobe(2, 16'h2222); tick(); idle(); tick(); tick();
        strobe(0, 16'h1111); strobe(2, 16'h3333); strobe(4, 16'h5555); tick();
        idle(); repeat (4) tick();
        chk("rr_level", level, 7);
        clr();
        strobe(1, 16'hABCD); tick(); idle(); tick(); tick();
        host_rd = 1; #1; chk("pop_dout", host_dout, 16'hABCD); tick();
        chk("pop_level", level, 0); #1; chk("empty_dout", host_dout, 0); tick();
        idle(); strobe(0, 16'h0F0F); tick(); idle(); tick();
        host_rd = 1; tick(); idle(); tick();
        chk("stale_rderr", rd_err, 1);
        clr();
        host_rd = 1; strobe(3, 16'hAAAA); tick(); strobe(3, 16'hBBBB); tick();
        ch_wr = '0; tick(); chk("coll_set", coll_err, 1);
        host_rd = 0; tick(); tick(); chk("coll_level", level, 1);
        clr();
        for (int i = 0; i < 17; i++) begin strobe(0, DW'(16'h100 + i)); tick(); end
        idle(); tick(); tick(); chk("full_level", level, 16);
        strobe(0, 16'hDEAD); tick(); idle(); tick();
        chk("full_ovfl", ovfl, 1); chk("full_coll", coll_err, 0);
        host_rd = 1; tick(); idle(); tick(); tick();
        chk("full_refill", level, 16);
        clr();
        host_rdy = 1; tick(); idle(); tick(); chk("hs_rdy", rdy, 1);
        poll = 1; ack = 0; tick(); chk("hs_noack", rdy, 1);
        ack = 1; #1; chk("hs_srq", host_srq, 1); tick();
        idle(); #1; chk("hs_clr", rdy, 0); chk("hs_srq0", host_srq, 0);
        host_rd = 1; strobe(4, 16'h4444); tick(); strobe(4, 16'h4545); tick();
        idle(); tick(); tick();
        strobe(1, 16'h7777); host_rd = 1; host_clr = 1; tick(); idle();
        chk("clr_level", level, 0); chk("clr_flags", {ovfl, coll_err, rd_err}, 0);
        tick(); chk("clr_pend", fif.fifo_we, 0);
        host_rdy = 1; tick(); idle(); strobe(0, 16'h9999); tick(); idle();
        #2; ha_rst = 1; #1;
        chk("arst_we", fif.fifo_we, 0); chk("arst_level", level, 0); chk("arst_rdy", rdy, 0);
        chk("arst_addr", fif.fifo_addr, 0);
        @(posedge hb_clk); #1; ha_rst = 0; mreset();
        for (int ph = 0; ph < 2; ph++)
            for (int c = 0; c < 400; c++) begin
                idle();
                for (int k = 0; k < NCH; k++) begin
                    ch_wr[k] = $urandom_range(3) == 0;
                    ch_din[k*DW +: DW] = DW'($urandom);
                end
                host_rd = ph == 0 ? $urandom_range(7) == 0 : $urandom_range(1) == 0;
                host_clr = $urandom_range(79) == 0;
                host_rdy = $urandom_range(7) == 0;
                poll = $urandom_range(3) == 0;
                ack = $urandom_range(1) == 0;
                tick();
            end
        idle(); tick();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
